// File: rtl/j1_periph_pkg.sv
// Shared address map, bit positions and channel decode for the J1 peripheral register bank.
package j1_periph_pkg;

   localparam int unsigned CTRL_A     = 0;
   localparam int unsigned STATUS_A   = 1;
   localparam int unsigned CFG_ADDR_A = 2;
   localparam int unsigned CFG_HI_A   = 3;
   localparam int unsigned CFG_LO_A   = 4;
   localparam int unsigned CH_BASE_A  = 8;

   localparam int unsigned CTRL_EN_B    = 0;
   localparam int unsigned CTRL_START_B = 1;

   localparam int unsigned ST_BUSY_B = 0;
   localparam int unsigned ST_REQ_B  = 1;
   localparam int unsigned ST_OVF_B  = 2;

   typedef struct packed {
      logic       valid;
      logic       hi;
      logic [3:0] ch;
   } ch_sel_t;

   // Channel k has its HI word at CH_BASE_A+2k and its LO word at CH_BASE_A+2k+1.
   function automatic ch_sel_t ch_index(input logic [15:0] a, input int unsigned n_ch);
      ch_sel_t     s;
      logic [15:0] off;
      off     = a - 16'(CH_BASE_A);
      s.valid = (a >= 16'(CH_BASE_A)) && (32'(off) < 2 * n_ch);
      s.hi    = ~off[0];
      s.ch    = 4'(off >> 1);
      return s;
   endfunction

endpackage

// File: rtl/j1_cfg_handshake.sv
// Config-write holding register with req/ack handshake and sticky overflow flag.
module j1_cfg_handshake #(
   parameter int unsigned CFG_AW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              commit,
   input  logic [CFG_AW-1:0] commit_addr,
   input  logic [31:0]       commit_data,
   input  logic              ack,
   input  logic              ovf_clr,
   output logic              req,
   output logic [CFG_AW-1:0] cfg_addr,
   output logic [31:0]       cfg_data,
   output logic              overflow
);

   logic              req_q, req_d;
   logic [CFG_AW-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic              ovf_q, ovf_d;
   logic              accept;

   // Next-state: a commit coinciding with an accepting ack reloads instead of overflowing.
   always_comb begin
      req_d  = req_q;
      addr_d = addr_q;
      data_d = data_q;
      ovf_d  = ovf_q;
      accept = req_q & ack;
      if (commit && (!req_q || accept)) begin
         req_d  = 1'b1;
         addr_d = commit_addr;
         data_d = commit_data;
      end else if (accept) begin
         req_d = 1'b0;
      end
      if (commit && req_q && !ack) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q  <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         req_q  <= req_d;
         addr_q <= addr_d;
         data_q <= data_d;
         ovf_q  <= ovf_d;
      end
   end

   assign req      = req_q;
   assign cfg_addr = addr_q;
   assign cfg_data = data_q;
   assign overflow = ovf_q;

endmodule

// File: rtl/j1_periph_regbank.sv
// J1-bus peripheral register bank: control, status, config-write port and atomic channel read-back.
module j1_periph_regbank
   import j1_periph_pkg::*;
#(
   parameter int unsigned N_CH   = 5,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CFG_AW = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cs,
   input  logic                 rd,
   input  logic                 wr,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [15:0]          d_in,
   output logic [15:0]          d_out,
   output logic                 en,
   output logic                 start,
   output logic [CFG_AW-1:0]    cfg_addr,
   output logic [31:0]          cfg_data,
   output logic                 cfg_req,
   input  logic                 cfg_ack,
   input  logic                 busy,
   input  logic [32*N_CH-1:0]   ch_data
);

   logic [15:0]       d_out_q, d_out_d;
   logic              en_q, en_d;
   logic              start_q, start_d;
   logic [CFG_AW-1:0] stg_addr_q, stg_addr_d;
   logic [15:0]       stg_hi_q, stg_hi_d;
   logic [15:0]       snap_q, snap_d;
   logic [3:0]        snap_ch_q, snap_ch_d;
   logic              snap_vld_q, snap_vld_d;

   logic              wr_s, rd_s, commit, ovf_clr, overflow;
   logic              is_ctrl, is_status, is_cfg_addr, is_cfg_hi, is_cfg_lo;
   ch_sel_t           sel;
   logic [31:0]       live;

   // Bus decode, register writes and registered read mux; a write strobe masks a coincident read.
   always_comb begin
      wr_s        = cs & wr;
      rd_s        = cs & rd & ~wr_s;
      is_ctrl     = (addr == ADDR_W'(CTRL_A));
      is_status   = (addr == ADDR_W'(STATUS_A));
      is_cfg_addr = (addr == ADDR_W'(CFG_ADDR_A));
      is_cfg_hi   = (addr == ADDR_W'(CFG_HI_A));
      is_cfg_lo   = (addr == ADDR_W'(CFG_LO_A));
      sel         = ch_index(16'(addr), N_CH);
      live        = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (sel.ch == 4'(k)) live = ch_data[32*k +: 32];
      end

      d_out_d    = d_out_q;
      en_d       = en_q;
      start_d    = 1'b0;
      stg_addr_d = stg_addr_q;
      stg_hi_d   = stg_hi_q;
      snap_d     = snap_q;
      snap_ch_d  = snap_ch_q;
      snap_vld_d = snap_vld_q;
      commit     = wr_s & is_cfg_lo;
      ovf_clr    = rd_s & is_status;

      if (wr_s) begin
         d_out_d = '0;
         if (is_ctrl) begin
            en_d    = d_in[CTRL_EN_B];
            start_d = d_in[CTRL_START_B];
         end
         if (is_cfg_addr) stg_addr_d = d_in[CFG_AW-1:0];
         if (is_cfg_hi)   stg_hi_d   = d_in;
      end else if (rd_s) begin
         d_out_d = '0;
         if (is_status) begin
            d_out_d[ST_BUSY_B] = busy;
            d_out_d[ST_REQ_B]  = cfg_req;
            d_out_d[ST_OVF_B]  = overflow;
         end else if (sel.valid) begin
            if (sel.hi) begin
               d_out_d    = live[31:16];
               snap_d     = live[15:0];
               snap_ch_d  = sel.ch;
               snap_vld_d = 1'b1;
            end else begin
               d_out_d = (snap_vld_q && (snap_ch_q == sel.ch)) ? snap_q : live[15:0];
            end
         end
      end
   end

   // Bank registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_out_q    <= '0;
         en_q       <= 1'b0;
         start_q    <= 1'b0;
         stg_addr_q <= '0;
         stg_hi_q   <= '0;
         snap_q     <= '0;
         snap_ch_q  <= '0;
         snap_vld_q <= 1'b0;
      end else begin
         d_out_q    <= d_out_d;
         en_q       <= en_d;
         start_q    <= start_d;
         stg_addr_q <= stg_addr_d;
         stg_hi_q   <= stg_hi_d;
         snap_q     <= snap_d;
         snap_ch_q  <= snap_ch_d;
         snap_vld_q <= snap_vld_d;
      end
   end

   j1_cfg_handshake #(.CFG_AW(CFG_AW)) u_hs (
      .clk         (clk),
      .rst         (rst),
      .commit      (commit),
      .commit_addr (stg_addr_q),
      .commit_data ({stg_hi_q, d_in}),
      .ack         (cfg_ack),
      .ovf_clr     (ovf_clr),
      .req         (cfg_req),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .overflow    (overflow)
   );

   assign d_out = d_out_q;
   assign en    = en_q;
   assign start = start_q;

endmodule
